// File: rtl/icache_direct_if.sv
// Fetch-side and refill-side signal bundle for the direct-mapped instruction cache.
// The cache takes the slave view; the core/memory environment takes the master view.
interface icache_direct_if #(
   parameter int ADDR_WIDTH  = 32,
   parameter int INSTR_WIDTH = 32
) ();
   logic                   imem_req;
   logic [ADDR_WIDTH-1:0]  imem_addr;
   logic [INSTR_WIDTH-1:0] imem_rdata;
   logic                   imem_valid;
   logic                   mem_req;
   logic [ADDR_WIDTH-1:0]  mem_addr;
   logic [INSTR_WIDTH-1:0] mem_rdata;
   logic                   mem_valid;
   logic                   flush;
   logic                   busy;
   logic [31:0]            hit_count;
   logic [31:0]            miss_count;

   modport slave (
      input  imem_req, imem_addr, mem_rdata, mem_valid, flush,
      output imem_rdata, imem_valid, mem_req, mem_addr, busy, hit_count, miss_count
   );

   modport master (
      output imem_req, imem_addr, mem_rdata, mem_valid, flush,
      input  imem_rdata, imem_valid, mem_req, mem_addr, busy, hit_count, miss_count
   );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache: whole-line in-order refill on miss,
// whole-cache invalidate, saturating hit/miss counters.
module icache_direct #(
   parameter int ADDR_WIDTH     = 32,
   parameter int INSTR_WIDTH    = 32,
   parameter int NUM_LINES      = 16,
   parameter int WORDS_PER_LINE = 4
) (
   input logic          clk,
   input logic          rst_n,
   icache_direct_if.slave bus
);
   localparam int WORD_BITS  = $clog2(WORDS_PER_LINE);
   localparam int INDEX_BITS = $clog2(NUM_LINES);
   localparam int INDEX_LSB  = 2 + WORD_BITS;
   localparam int TAG_LSB    = INDEX_LSB + INDEX_BITS;
   localparam int TAG_BITS   = ADDR_WIDTH - TAG_LSB;

   typedef enum logic [2:0] {IDLE, RESPOND, REFILL, FILL_DONE, FLUSH} state_t;

   state_t                  state_reg;
   logic [NUM_LINES-1:0]    valid_reg;
   logic [TAG_BITS-1:0]     tag_mem  [NUM_LINES];
   logic [INSTR_WIDTH-1:0]  data_mem [NUM_LINES][WORDS_PER_LINE];

   logic [TAG_BITS-1:0]     req_tag_reg;
   logic [INDEX_BITS-1:0]   req_index_reg;
   logic [WORD_BITS-1:0]    req_word_reg;
   logic [WORD_BITS-1:0]    fill_cnt_reg;
   logic                    flush_pending_reg;
   logic                    imem_valid_reg;
   logic [INSTR_WIDTH-1:0]  imem_rdata_reg;
   logic                    mem_req_reg;
   logic [ADDR_WIDTH-1:0]   mem_addr_reg;
   logic [31:0]             hit_count_reg;
   logic [31:0]             miss_count_reg;

   logic [TAG_BITS-1:0]     req_tag;
   logic [INDEX_BITS-1:0]   req_index;
   logic [WORD_BITS-1:0]    req_word;
   logic                    lookup_hit;
   logic                    fill_last;
   logic                    unused_addr_bits;

   assign req_tag          = bus.imem_addr[ADDR_WIDTH-1:TAG_LSB];
   assign req_index        = bus.imem_addr[TAG_LSB-1:INDEX_LSB];
   assign req_word         = bus.imem_addr[INDEX_LSB-1:2];
   assign unused_addr_bits = ^bus.imem_addr[1:0];
   assign lookup_hit       = valid_reg[req_index] && (tag_mem[req_index] == req_tag);
   assign fill_last        = (fill_cnt_reg == WORD_BITS'(WORDS_PER_LINE - 1));

   // Line storage carries no reset: valid_reg alone decides whether contents are used.
   always_ff @(posedge clk) begin
      if (state_reg == REFILL && bus.mem_valid) begin
         data_mem[req_index_reg][fill_cnt_reg] <= bus.mem_rdata;
         if (fill_last)
            tag_mem[req_index_reg] <= req_tag_reg;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg         <= IDLE;
         valid_reg         <= '0;
         req_tag_reg       <= '0;
         req_index_reg     <= '0;
         req_word_reg      <= '0;
         fill_cnt_reg      <= '0;
         flush_pending_reg <= 1'b0;
         imem_valid_reg    <= 1'b0;
         imem_rdata_reg    <= '0;
         mem_req_reg       <= 1'b0;
         mem_addr_reg      <= '0;
         hit_count_reg     <= '0;
         miss_count_reg    <= '0;
      end else begin
         imem_valid_reg <= 1'b0;
         if (bus.flush)
            flush_pending_reg <= 1'b1;

         case (state_reg)
            IDLE: begin
               if (flush_pending_reg || bus.flush) begin
                  flush_pending_reg <= 1'b0;
                  state_reg         <= FLUSH;
               end else if (bus.imem_req) begin
                  req_tag_reg   <= req_tag;
                  req_index_reg <= req_index;
                  req_word_reg  <= req_word;
                  if (lookup_hit) begin
                     imem_rdata_reg <= data_mem[req_index][req_word];
                     imem_valid_reg <= 1'b1;
                     if (hit_count_reg != '1)
                        hit_count_reg <= hit_count_reg + 32'd1;
                     state_reg <= RESPOND;
                  end else begin
                     if (miss_count_reg != '1)
                        miss_count_reg <= miss_count_reg + 32'd1;
                     fill_cnt_reg <= '0;
                     mem_req_reg  <= 1'b1;
                     mem_addr_reg <= {req_tag, req_index, {WORD_BITS{1'b0}}, 2'b00};
                     state_reg    <= REFILL;
                  end
               end
            end
            RESPOND: state_reg <= IDLE;
            REFILL: begin
               // The address only advances once the current word has been returned.
               if (bus.mem_valid) begin
                  if (fill_last) begin
                     mem_req_reg              <= 1'b0;
                     valid_reg[req_index_reg] <= 1'b1;
                     state_reg                <= FILL_DONE;
                  end else begin
                     fill_cnt_reg <= fill_cnt_reg + WORD_BITS'(1);
                     mem_addr_reg <= mem_addr_reg + ADDR_WIDTH'(4);
                  end
               end
            end
            FILL_DONE: begin
               imem_rdata_reg <= data_mem[req_index_reg][req_word_reg];
               imem_valid_reg <= 1'b1;
               state_reg      <= RESPOND;
            end
            FLUSH: begin
               valid_reg <= '0;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.imem_valid = imem_valid_reg;
   assign bus.imem_rdata = imem_rdata_reg;
   assign bus.mem_req    = mem_req_reg;
   assign bus.mem_addr   = mem_addr_reg;
   assign bus.busy       = (state_reg != IDLE);
   assign bus.hit_count  = hit_count_reg;
   assign bus.miss_count = miss_count_reg;
endmodule

// File: tb/tb_icache_direct.sv
// Randomized bench for icache_direct against an array-based cache model and a
// memory responder with programmable per-word delay.
module tb_icache_direct;
   logic clk;
   logic rst_n;
   int   tests;
   int   failed;
   int   mem_delay;
   int   words_got;
   logic [31:0] addr_log[$];

   bit          m_valid [16];
   logic [31:0] m_tag   [16];
   int unsigned m_hits;
   int unsigned m_misses;

   icache_direct_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32)) bus ();

   icache_direct #(
      .ADDR_WIDTH(32), .INSTR_WIDTH(32), .NUM_LINES(16), .WORDS_PER_LINE(4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Backing memory contents: line 0x100 holds 0xA0..0xA3, everything else a hash.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a[31:4] == 28'h0000010)
         return 32'hA0 + 32'(a[3:2]);
      return (a * 32'h9E3779B9) ^ 32'h5A5A0F0F;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
      m_hits   = 0;
      m_misses = 0;
   endfunction

   function automatic void model_flush();
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
   endfunction

   // Memory responder: answers each word after mem_delay idle cycles, checks stability while stalled.
   initial begin
      int          wait_cnt;
      logic [31:0] hold_addr;
      wait_cnt      = 0;
      hold_addr     = '0;
      words_got     = 0;
      bus.mem_valid = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(negedge clk);
         bus.mem_valid = 1'b0;
         if (rst_n && bus.mem_req) begin
            if (wait_cnt == 0) hold_addr = bus.mem_addr;
            else chk("mem_addr_stable", bus.mem_addr, hold_addr);
            if (wait_cnt >= mem_delay) begin
               bus.mem_valid = 1'b1;
               bus.mem_rdata = mem_word(bus.mem_addr);
               addr_log.push_back(bus.mem_addr);
               words_got++;
               wait_cnt = 0;
            end else begin
               wait_cnt++;
            end
         end else begin
            if (rst_n && wait_cnt != 0) chk("mem_req_held", 32'(bus.mem_req), 32'd1);
            wait_cnt = 0;
         end
      end
   end

   task automatic fetch(input logic [31:0] addr, input int flush_word);
      int          idx;
      logic [31:0] tag;
      bit          exp_hit;
      int          exp_lat;
      int          n;
      int          base_words;
      bit          got;
      bit          flushed;
      logic [31:0] line;
      idx     = int'((addr >> 4) % 16);
      tag     = addr >> 8;
      line    = {addr[31:4], 4'h0};
      exp_hit = m_valid[idx] && (m_tag[idx] == tag);
      exp_lat = exp_hit ? 1 : 4 * (mem_delay + 1) + 2;
      repeat (3) @(negedge clk);
      addr_log.delete();
      base_words    = words_got;
      bus.imem_addr = addr;
      bus.imem_req  = 1'b1;
      n       = 0;
      got     = 1'b0;
      flushed = 1'b0;
      while (n < 300 && !got) begin
         @(negedge clk);
         #1;
         n++;
         bus.flush = 1'b0;
         if (flush_word >= 0 && !flushed && bus.mem_req && (words_got - base_words) == flush_word) begin
            bus.flush = 1'b1;
            flushed   = 1'b1;
         end
         if (bus.imem_valid) got = 1'b1;
      end
      bus.imem_req = 1'b0;
      bus.flush    = 1'b0;
      chk("response_seen", 32'(got), 32'd1);
      chk("rdata", bus.imem_rdata, mem_word({addr[31:2], 2'b00}));
      chk("latency", 32'(n), 32'(exp_lat));
      if (exp_hit) begin
         m_hits++;
      end else begin
         m_misses++;
         m_valid[idx] = 1'b1;
         m_tag[idx]   = tag;
      end
      if (flushed) model_flush();
      chk("refill_words", 32'(addr_log.size()), exp_hit ? 32'd0 : 32'd4);
      for (int i = 0; i < addr_log.size() && i < 4; i++)
         chk("refill_addr", addr_log[i], line + 32'(4 * i));
      @(negedge clk);
      #1;
      chk("valid_one_cycle", 32'(bus.imem_valid), 32'd0);
      chk("hit_count", bus.hit_count, m_hits);
      chk("miss_count", bus.miss_count, m_misses);
      $display("[TB] fetch addr=%h %s delay=%0d lat=%0d rdata=%h flush=%0d", addr,
               exp_hit ? "hit " : "miss", mem_delay, n, bus.imem_rdata, flushed);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_imem_valid"}, 32'(bus.imem_valid), 32'd0);
      chk({tag, "_imem_rdata"}, bus.imem_rdata, 32'd0);
      chk({tag, "_mem_req"}, 32'(bus.mem_req), 32'd0);
      chk({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_hit_count"}, bus.hit_count, 32'd0);
      chk({tag, "_miss_count"}, bus.miss_count, 32'd0);
   endtask

   initial begin
      int          n;
      logic [31:0] a;
      tests         = 0;
      failed        = 0;
      mem_delay     = 1;
      rst_n         = 1'b0;
      bus.imem_req  = 1'b0;
      bus.imem_addr = '0;
      bus.flush     = 1'b0;
      model_reset();
      #1;
      check_reset_outputs("reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      fetch(32'h100, -1);
      fetch(32'h108, -1);
      fetch(32'h200, -1);
      fetch(32'h100, -1);
      mem_delay = 5;
      fetch(32'h340, -1);
      mem_delay = 1;
      fetch(32'h480, 1);
      fetch(32'h480, -1);

      // Reset in the middle of a refill, after two words have been returned.
      repeat (3) @(negedge clk);
      bus.imem_addr = 32'h5C4;
      bus.imem_req  = 1'b1;
      n = words_got;
      for (int i = 0; i < 100 && words_got < n + 2; i++) @(negedge clk);
      chk("two_words_before_reset", 32'(words_got - n), 32'd2);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_refill_reset");
      bus.imem_req = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      fetch(32'h5C4, -1);

      // Random traffic over a small address pool so hits, conflicts and flushes mix.
      for (int t = 0; t < 40; t++) begin
         mem_delay = int'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) begin
            @(negedge clk);
            bus.flush = 1'b1;
            @(negedge clk);
            bus.flush = 1'b0;
            model_flush();
         end
         a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 4) |
             ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
         fetch(a, ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
